ls_result_drain: RTL
====================

// Module: ls_result_drain
// PURPOSE
//  Store-side counterpart of the load/store array: accepts one wide result vector
//  (COLUMNS lanes) from the MXU and serializes it, one lane per cycle, into the output FIFO.
//  The CU programs the number of lanes to emit (precision-dependent).
//  The block sits between the MXU result port and the output FIFO write port.
// PARAMETERS
//  COLUMNS         4   number of MXU result lanes
//  data_out_width  64  width of one lane and of the output FIFO word
// PORTS
//  clk                  in   1                      clock, rising edge
//  reset_n              in   1                      asynchronous reset, ACTIVE-HIGH despite the name
//  result_valid         in   1                      MXU presents a result vector
//  result_ready         out  1                      block accepts the vector this cycle
//  data_from_mxu        in   data_out_width*COLUMNS lane i = bits [i*data_out_width +: data_out_width]
//  ld_max_cnt           in   1                      load the lane-count register
//  max_cnt_from_cu      in   $clog2(COLUMNS)+1      index of the last lane to emit
//  outfifo_full         in   1                      output FIFO cannot accept a write
//  outfifo_write        out  1                      write strobe to the output FIFO
//  output_data_to_fifo  out  data_out_width         lane being written
//  busy                 out  1                      state == DRAIN
//  done                 out  1                      1-cycle pulse after the last lane of a vector is written
// BEHAVIOUR
//  - Reset (async, reset_n=1): state=IDLE, buffer=0, counter=0, max_cnt=COLUMNS-1, done=0.
//    Outputs: result_ready=1, outfifo_write=0, output_data_to_fifo=0, busy=0.
//  - max_cnt register:
//    - loads only when ld_max_cnt=1 and state=IDLE; ld_max_cnt during DRAIN is ignored.
//    - values > COLUMNS-1 are clamped to COLUMNS-1.
//  - FSM state IDLE:
//    - result_ready=1.
//    - result_valid=1 -> buffer<=data_from_mxu, counter<=0, next state DRAIN.
//  - FSM state DRAIN:
//    - output_data_to_fifo = buffer lane[counter]; this is a combinational mux from registers.
//    - outfifo_write = !outfifo_full. The full signal is sampled in the same cycle; no write is issued while full.
//    - On a write with counter!=max_cnt: counter<=counter+1.
//    - On a write with counter==max_cnt: done<=1 for the next cycle.
//      - If result_valid=1 in the same cycle: capture the new vector, counter<=0, stay in DRAIN.
//      - Otherwise: next state IDLE.
//    - result_ready = (counter==max_cnt) && !outfifo_full. This lets vectors run back-to-back with no bubble.
//    - While outfifo_full=1: counter, buffer and state hold; result_ready=0.
//  - Latency: vector captured at edge N -> lane 0 is written in cycle N+1.
//    With no stalls, lane k is written in cycle N+1+k.
//  - Lanes above max_cnt are discarded and never written.
//  - output_data_to_fifo = 0 in IDLE.
//  - The counter never wraps past max_cnt. It is $clog2(COLUMNS)+1 bits wide.
//  - Reset asserted mid-DRAIN: the in-flight vector is dropped and all state returns to reset values
//    immediately, with no clock edge needed.
// TESTING
//  1. Reset check: assert reset_n mid-simulation -> result_ready=1, outfifo_write=0, busy=0, done=0,
//     output_data_to_fifo=0 immediately.
//  2. Full vector, no stalls: COLUMNS=4, max_cnt=3,
//     lanes = 64'h11..11, 64'h22..22, 64'h33..33, 64'h44..44, outfifo_full=0
//     -> 4 writes in cycles N+1..N+4 in lane order; done pulse in N+5; result_ready=1 again.
//  3. Back-pressure: outfifo_full=1 for 3 cycles after the lane-0 write
//     -> no writes during those cycles; output_data_to_fifo holds 64'h22..22;
//     lane 1 is written on the first cycle with full=0.
//  4. Reduced count and clamp:
//     - ld_max_cnt with value 1 in IDLE -> only lanes 0 and 1 are written; done follows the 2nd write.
//     - load value 7 -> register reads 3 (clamped).
//     - ld_max_cnt during DRAIN -> count unchanged.
//  5. Back-to-back: result_valid held high for 2 vectors with max_cnt=3
//     -> 8 contiguous writes with no idle cycle; done pulses after write 4 and after write 8.
//  6. Reset mid-DRAIN: assert reset after the 2nd write -> writes stop at once;
//     after release, a new vector drains from lane 0.

Source files
------------

// File: rtl/ls_result_drain.sv
// Serializes one wide MXU result vector into the output FIFO, one lane per cycle.
// States: IDLE | waiting for a result vector ; DRAIN | writing buffered lanes 0..max_cnt
module ls_result_drain #(
  parameter int COLUMNS        = 4,
  parameter int data_out_width = 64
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                result_valid,
  output logic                                result_ready,
  input  logic [data_out_width*COLUMNS-1:0]   data_from_mxu,
  input  logic                                ld_max_cnt,
  input  logic [$clog2(COLUMNS):0]            max_cnt_from_cu,
  input  logic                                outfifo_full,
  output logic                                outfifo_write,
  output logic [data_out_width-1:0]           output_data_to_fifo,
  output logic                                busy,
  output logic                                done
);

  localparam int CW = $clog2(COLUMNS) + 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(COLUMNS - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                             state_q, state_d;
  logic [data_out_width*COLUMNS-1:0]  buf_q, buf_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [CW-1:0]                      max_q, max_d;
  logic                               done_q, done_d;
  logic [data_out_width-1:0]          lane;
  logic                               last;

  // reset_n is active-high despite its name
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      max_q   <= LAST_LANE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    lane = '0;
    for (int i = 0; i < COLUMNS; i++) begin
      if (cnt_q == CW'(i)) lane = buf_q[i*data_out_width +: data_out_width];
    end
  end

  assign last = (cnt_q == max_q);

  always_comb begin
    state_d             = state_q;
    buf_d               = buf_q;
    cnt_d               = cnt_q;
    max_d               = max_q;
    done_d              = 1'b0;
    result_ready        = 1'b0;
    outfifo_write       = 1'b0;
    output_data_to_fifo = '0;
    busy                = 1'b0;

    case (state_q)
      IDLE: begin
        result_ready = 1'b1;
        if (ld_max_cnt) begin
          max_d = (max_cnt_from_cu > LAST_LANE) ? LAST_LANE : max_cnt_from_cu;
        end
        if (result_valid) begin
          buf_d   = data_from_mxu;
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy                = 1'b1;
        output_data_to_fifo = lane;
        outfifo_write       = !outfifo_full;
        // Ready on the last lane lets the next vector follow with no bubble
        result_ready        = last && !outfifo_full;
        if (!outfifo_full) begin
          if (!last) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            done_d = 1'b1;
            if (result_valid) begin
              buf_d = data_from_mxu;
              cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done = done_q;

endmodule
